bmp_window_resampler: RTL and testbench

//  Successor to the fixed-RGB BMP crop engine. Copies a rectangular window of a bottom-up
//  BMP pixel array into a new BMP pixel array, with padded rows (multiple of 4 bytes).

---
 rtl/bmp_pkg.sv | 26 ++
 rtl/bmp_slot_delay.sv | 28 ++
 rtl/bmp_window_resampler.sv | 215 +++++++++++++++++++++
 tb/tb_bmp_window_resampler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_pkg.sv
// Shared types for the BMP window resampler.
// State encoding, slot bundle and row padding helper.
package bmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned BMP_ROW_ALIGN = 4;

  typedef struct packed {
    logic        valid;
    logic        is_pad;
    logic [31:0] addr;
  } slot_t;

  function automatic logic [31:0] pad_row(input logic [31:0] bytes);
    return (bytes + 32'(BMP_ROW_ALIGN - 1))
           & ~32'(BMP_ROW_ALIGN - 1);
  endfunction

endpackage

// File: rtl/bmp_slot_delay.sv
// Slot delay line matching the source RAM read latency.
// Keeps each write aligned with the data it carries.
module bmp_slot_delay
  import bmp_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  slot_t din,
  output slot_t dout
);

  slot_t pipe [RD_LAT];

  // shift slots one stage per cycle; reset discards in-flight slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[RD_LAT-1];

endmodule

// File: rtl/bmp_window_resampler.sv
// Copies a decimated, optionally flipped window of a BMP pixel
// array into a padded output pixel array, one byte per cycle.
module bmp_window_resampler
  import bmp_pkg::*;
#(
  parameter int IMG_W     = 100,
  parameter int IMG_H     = 100,
  parameter int BPP       = 3,
  parameter int RD_LAT    = 1,
  parameter int HDR_BYTES = 54,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [10:0]       x_min,
  input  logic [10:0]       x_max,
  input  logic [10:0]       y_min,
  input  logic [10:0]       y_max,
  input  logic [1:0]        step_log2,
  input  logic              flip_v,
  output logic [31:0]       rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [31:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       out_bytes
);

  localparam logic [31:0] ROW_SRC = 32'(IMG_W * BPP);
  localparam logic [31:0] BPP32   = 32'(BPP);
  localparam logic [1:0]  C_LAST  = 2'(BPP - 1);
  localparam logic [2:0]  D_LAST  = 3'(RD_LAT - 1);

  state_t      state, state_nx;
  logic [10:0] xmn, xmx, ymn, ymx;
  logic [1:0]  sl;
  logic        flip;
  logic [10:0] r, k;
  logic [1:0]  c, p;
  logic        in_pad;
  logic [31:0] row_src, wr_ptr;
  logic [2:0]  dcnt;
  slot_t       slot_in, slot_out;

  logic        accept, bad;
  logic [10:0] ow_m1, oh_m1;
  logic [31:0] row_bytes, prow, y_first, src_first;
  logic [31:0] row_step, col_step, next_row;
  logic [1:0]  pad_n;
  logic [63:0] ob_full;
  logic        byte_last, col_last, pad_last;
  logic        row_end, img_last;

  assign accept = start && (state == IDLE || state == DONE);

  assign bad = (xmx < xmn) || (ymx < ymn)
            || (32'(xmx) >= 32'(IMG_W))
            || (32'(ymx) >= 32'(IMG_H))
            || (sl == 2'd3);

  assign ow_m1     = (xmx - xmn) >> sl;
  assign oh_m1     = (ymx - ymn) >> sl;
  assign row_bytes = (32'(ow_m1) + 32'd1) * BPP32;
  assign prow      = pad_row(row_bytes);
  assign pad_n     = 2'(prow - row_bytes);
  assign ob_full   = 64'(prow) * 64'(32'(oh_m1) + 32'd1);
  assign y_first   = flip ? 32'(ymn) + (32'(oh_m1) << sl)
                          : 32'(ymn);
  assign src_first = (32'(IMG_H - 1) - y_first) * ROW_SRC
                   + 32'(xmn) * BPP32;
  assign row_step  = ROW_SRC << sl;
  assign col_step  = (BPP32 << sl) - 32'(BPP - 1);
  assign next_row  = flip ? row_src + row_step
                          : row_src - row_step;

  assign byte_last = (c == C_LAST);
  assign col_last  = (k == ow_m1);
  assign pad_last  = (p == pad_n - 2'd1);
  assign row_end   = in_pad ? pad_last
                   : (byte_last && col_last && pad_n == 2'd0);
  assign img_last  = row_end && (r == oh_m1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = CHECK;
      CHECK: state_nx = bad ? DONE : RUN;
      RUN:   if (img_last) state_nx = DRAIN;
      DRAIN: if (dcnt == D_LAST) state_nx = DONE;
      DONE:  if (accept) state_nx = CHECK;
      default: state_nx = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      state == CHECK,
      state == RUN,
      state == DRAIN: busy = 1'b1;
      state == DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // window latch, address generator and run counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmn       <= '0;
      xmx       <= '0;
      ymn       <= '0;
      ymx       <= '0;
      sl        <= '0;
      flip      <= 1'b0;
      r         <= '0;
      k         <= '0;
      c         <= '0;
      p         <= '0;
      in_pad    <= 1'b0;
      row_src   <= '0;
      rd_addr   <= '0;
      wr_ptr    <= '0;
      dcnt      <= '0;
      err       <= 1'b0;
      out_bytes <= '0;
    end else begin
      if (accept) begin
        xmn  <= x_min;
        xmx  <= x_max;
        ymn  <= y_min;
        ymx  <= y_max;
        sl   <= step_log2;
        flip <= flip_v;
        err  <= 1'b0;
      end
      case (state)
        CHECK: begin
          err       <= bad;
          out_bytes <= bad ? '0
                     : (|ob_full[63:32] ? '1 : ob_full[31:0]);
          r         <= '0;
          k         <= '0;
          c         <= '0;
          p         <= '0;
          in_pad    <= 1'b0;
          row_src   <= src_first;
          rd_addr   <= src_first;
          wr_ptr    <= 32'(HDR_BYTES);
          dcnt      <= '0;
        end
        RUN: begin
          wr_ptr <= wr_ptr + 32'd1;
          if (row_end) begin
            if (!img_last) begin
              r       <= r + 11'd1;
              k       <= '0;
              c       <= '0;
              p       <= '0;
              in_pad  <= 1'b0;
              row_src <= next_row;
              rd_addr <= next_row;
            end
          end else if (in_pad) begin
            p <= p + 2'd1;
          end else if (!byte_last) begin
            c       <= c + 2'd1;
            rd_addr <= rd_addr + 32'd1;
          end else if (!col_last) begin
            c       <= '0;
            k       <= k + 11'd1;
            rd_addr <= rd_addr + col_step;
          end else begin
            c      <= '0;
            p      <= '0;
            in_pad <= 1'b1;
          end
        end
        DRAIN: dcnt <= dcnt + 3'd1;
        default: ;
      endcase
    end
  end

  assign slot_in = '{valid:  (state == RUN),
                     is_pad: in_pad,
                     addr:   wr_ptr};

  bmp_slot_delay #(
    .RD_LAT (RD_LAT)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (slot_in),
    .dout (slot_out)
  );

  assign wren    = slot_out.valid;
  assign wr_addr = slot_out.addr;
  assign wr_data = (slot_out.valid && !slot_out.is_pad)
                 ? rd_data : '0;

endmodule

// File: tb/tb_bmp_window_resampler.sv
// Scoreboard bench for bmp_window_resampler on an 8x4 image,
// one instance at BPP=3/RD_LAT=1 and one at BPP=4/RD_LAT=3.
module tb_bmp_window_resampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic [1:0]  step_log2;
  logic        flip_v;

  logic [31:0] rd_addr_a, wr_addr_a, out_bytes_a;
  logic [15:0] rd_data_a, wr_data_a;
  logic        wren_a, busy_a, done_a, err_a;
  logic [31:0] rd_addr_b, wr_addr_b, out_bytes_b;
  logic [15:0] rd_data_b, wr_data_b;
  logic        wren_b, busy_b, done_b, err_b;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;

  always #5 clk = ~clk;

  bmp_window_resampler #(
    .IMG_W(8), .IMG_H(4), .BPP(3), .RD_LAT(1),
    .HDR_BYTES(54), .DATA_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max),
    .step_log2(step_log2), .flip_v(flip_v),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .wren(wren_a), .busy(busy_a), .done(done_a),
    .err(err_a), .out_bytes(out_bytes_a)
  );

  bmp_window_resampler #(
    .IMG_W(8), .IMG_H(4), .BPP(4), .RD_LAT(3),
    .HDR_BYTES(54), .DATA_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max),
    .step_log2(step_log2), .flip_v(flip_v),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wren(wren_b), .busy(busy_b), .done(done_b),
    .err(err_b), .out_bytes(out_bytes_b)
  );

  function automatic logic [15:0] mem(input logic [31:0] a);
    return 16'((a * 3 + 1) & 32'hFF);
  endfunction

  logic [15:0] pa;
  logic [15:0] pb [3];

  always @(posedge clk) pa <= mem(rd_addr_a);
  assign rd_data_a = pa;

  always @(posedge clk) begin
    pb[0] <= mem(rd_addr_b);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign rd_data_b = pb[2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wren_a) begin
      chk("a_wr_expected", 32'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_wr_addr", wr_addr_a, e.addr);
        chk("a_wr_data", 32'(wr_data_a), e.data);
        wr_cnt_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (wren_b) begin
      chk("b_wr_expected", 32'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_wr_addr", wr_addr_b, e.addr);
        chk("b_wr_data", 32'(wr_data_b), e.data);
        wr_cnt_b++;
      end
    end
  end

  task automatic model(input bit sel, input int xmn, input int xmx,
                       input int ymn, input int ymx, input int sl,
                       input bit flip, output int ob);
    int bpp, s, ow, oh, rb, pr, y, src;
    exp_t e;
    bpp = sel ? 4 : 3;
    s   = 1 << sl;
    ow  = ((xmx - xmn) >> sl) + 1;
    oh  = ((ymx - ymn) >> sl) + 1;
    rb  = ow * bpp;
    pr  = ((rb + 3) / 4) * 4;
    ob  = pr * oh;
    for (int r = 0; r < oh; r++) begin
      y = flip ? ymn + (oh - 1 - r) * s : ymn + r * s;
      for (int k = 0; k < ow; k++) begin
        for (int c = 0; c < bpp; c++) begin
          src    = (3 - y) * 8 * bpp + (xmn + k * s) * bpp + c;
          e.addr = 54 + r * pr + k * bpp + c;
          e.data = int'(mem(32'(src)));
          if (sel) q_b.push_back(e);
          else     q_a.push_back(e);
        end
      end
      for (int p = rb; p < pr; p++) begin
        e.addr = 54 + r * pr + p;
        e.data = 0;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
      end
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // poke: 0 none, 1 start mid-run, 2 start in last DRAIN cycle
  task automatic run(input string tag, input bit sel,
                     input int xmn, input int xmx,
                     input int ymn, input int ymx, input int sl,
                     input bit flip, input bit bad,
                     input int exp_first, input int poke);
    int ob, lat, dedge, n, first, wc0;
    logic dn, wr;
    ob  = 0;
    lat = sel ? 3 : 1;
    if (!bad) model(sel, xmn, xmx, ymn, ymx, sl, flip, ob);
    dedge = bad ? 2 : 2 + ob + lat;
    wc0   = sel ? wr_cnt_b : wr_cnt_a;
    x_min = 11'(xmn);
    x_max = 11'(xmx);
    y_min = 11'(ymn);
    y_max = 11'(ymx);
    step_log2 = 2'(sl);
    flip_v = flip;
    set_start(sel, 1'b1);
    n = 0;
    first = 0;
    while (n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      dn = sel ? done_b : done_a;
      wr = sel ? wren_b : wren_a;
      if (n == 1) begin
        set_start(sel, 1'b0);
        chk({tag, "_busy_check"}, sel ? busy_b : busy_a, 1);
        chk({tag, "_done_check"}, dn, 0);
      end
      if (poke == 1 && n == 3) begin
        set_start(sel, 1'b1);
        x_min  = 11'd0;
        flip_v = !flip;
      end
      if (poke == 1 && n == 4) set_start(sel, 1'b0);
      if (poke == 2 && n == dedge - 1) set_start(sel, 1'b1);
      if (first == 0 && wr) first = n;
      if (dn) break;
    end
    set_start(sel, 1'b0);
    chk({tag, "_done_edge"}, n, dedge);
    chk({tag, "_err"}, sel ? err_b : err_a, 32'(bad));
    chk({tag, "_busy_end"}, sel ? busy_b : busy_a, 0);
    if (!bad)
      chk({tag, "_out_bytes"}, sel ? out_bytes_b : out_bytes_a, ob);
    if (exp_first > 0) chk({tag, "_first_wren"}, first, exp_first);
    @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, sel ? done_b : done_a, 1);
    chk({tag, "_q_left"}, sel ? q_b.size() : q_a.size(), 0);
    chk({tag, "_wr_count"}, (sel ? wr_cnt_b : wr_cnt_a) - wc0, ob);
  endtask

  initial begin
    int ob;
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    x_min = '0;
    x_max = '0;
    y_min = '0;
    y_max = '0;
    step_log2 = '0;
    flip_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk("rst_wr_data", 32'(wr_data_a), 0);
    chk("rst_out_bytes", out_bytes_a, 0);
    chk("rst_wren", wren_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_wren_b", wren_b, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("crop_1x2", 0, 1, 2, 0, 0, 0, 0, 0, 3, 2);
    run("bpp4_lat3", 1, 0, 3, 0, 1, 0, 0, 0, 5, 0);
    run("step1", 0, 0, 4, 0, 2, 1, 0, 0, 0, 1);
    run("step1_flip", 0, 0, 4, 0, 2, 1, 1, 0, 0, 0);
    run("err_xmax", 0, 0, 8, 0, 0, 0, 0, 1, 0, 0);
    run("err_step3", 0, 0, 1, 0, 0, 3, 0, 1, 0, 0);
    run("err_ymax", 0, 0, 1, 0, 4, 0, 0, 1, 0, 0);
    run("err_xrev", 0, 2, 1, 0, 0, 0, 0, 1, 0, 0);
    run("one_px", 0, 7, 7, 3, 3, 0, 0, 0, 0, 0);
    run("full_w_flip", 0, 0, 7, 1, 3, 0, 1, 0, 0, 0);
    run("b_step_flip", 1, 1, 6, 0, 3, 1, 1, 0, 5, 0);

    model(0, 0, 7, 0, 3, 0, 0, ob);
    x_min = 11'd0;
    x_max = 11'd7;
    y_min = 11'd0;
    y_max = 11'd3;
    step_log2 = 2'd0;
    flip_v = 1'b0;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", wren_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_wr_data", 32'(wr_data_a), 0);
    q_a.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("after_rst", 0, 1, 2, 0, 0, 0, 0, 0, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
